// File: rtl/rom_controller.sv
// Streams a 4-word constant ROM to the downstream store, then pulses a kick to the network controller.
// Optional feature: define ROM_CTRL_CHECKSUM_EN to add an XOR checksum output of the streamed words.
module rom_controller #(
   parameter logic [31:0] ROM_WORD0 = 32'h1111_1111,
   parameter logic [31:0] ROM_WORD1 = 32'h2222_2222,
   parameter logic [31:0] ROM_WORD2 = 32'h4444_4444,
   parameter logic [31:0] ROM_WORD3 = 32'h8888_8888
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [0:31] rom_output,
   output logic [1:0]  address,
   output logic        writeData,
   output logic        start_network_controller
`ifdef ROM_CTRL_CHECKSUM_EN
   ,
   output logic [31:0] checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic        start_q;
   logic [31:0] rom_q, rom_d;
   logic [1:0]  addr_q, addr_d;
   logic        wr_q, wr_d;
   logic        kick_q, kick_d;
   logic [31:0] rom_word;
   logic        trigger;
`ifdef ROM_CTRL_CHECKSUM_EN
   logic [31:0] cks_q, cks_d;
`endif

   assign trigger = start & ~start_q;

   always_comb begin
      rom_word = ROM_WORD0;
      case (idx_q)
         2'd0:    rom_word = ROM_WORD0;
         2'd1:    rom_word = ROM_WORD1;
         2'd2:    rom_word = ROM_WORD2;
         default: rom_word = ROM_WORD3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rom_d   = '0;
      addr_d  = '0;
      wr_d    = 1'b0;
      kick_d  = 1'b0;
`ifdef ROM_CTRL_CHECKSUM_EN
      cks_d   = cks_q;
`endif
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d = XFER;
               idx_d   = 2'd0;
`ifdef ROM_CTRL_CHECKSUM_EN
               cks_d   = '0;
`endif
            end
         end
         XFER: begin
            addr_d = idx_q;
            rom_d  = rom_word;
            wr_d   = 1'b1;
            idx_d  = idx_q + 2'd1;
`ifdef ROM_CTRL_CHECKSUM_EN
            cks_d  = cks_q ^ rom_word;
`endif
            // The last word leaves through DONE, so idx wrapping to 0 is never used.
            if (idx_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            kick_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         start_q <= 1'b0;
         rom_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         kick_q  <= 1'b0;
`ifdef ROM_CTRL_CHECKSUM_EN
         cks_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         start_q <= start;
         rom_q   <= rom_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         kick_q  <= kick_d;
`ifdef ROM_CTRL_CHECKSUM_EN
         cks_q   <= cks_d;
`endif
      end
   end

   assign rom_output               = rom_q;
   assign address                  = addr_q;
   assign writeData                = wr_q;
   assign start_network_controller = kick_q;
`ifdef ROM_CTRL_CHECKSUM_EN
   assign checksum                 = cks_q;
`endif

endmodule

// File: tb/tb_rom_controller.sv
// Directed bench for rom_controller: expected words are queued at each trigger and popped as writes appear.
// Covers reset, single run, held start, ignored retrigger, abort, and the ROM_CTRL_CHECKSUM_EN checksum.
module tb_rom_controller;

   typedef struct packed {
      logic [1:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [0:31] rom_output;
   logic [1:0]  address;
   logic        writeData;
   logic        start_network_controller;
`ifdef ROM_CTRL_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int   total;
   int   bad;
   int   dones;
   int   exp_dones;
   exp_t exp_q[$];
   logic [31:0] rom_ref [4];

   rom_controller dut (
      .clk                      (clk),
      .reset                    (reset),
      .start                    (start),
      .rom_output               (rom_output),
      .address                  (address),
      .writeData                (writeData),
      .start_network_controller (start_network_controller)
`ifdef ROM_CTRL_CHECKSUM_EN
      ,
      .checksum                 (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_run();
      for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 2'(i), data: rom_ref[i]});
   endtask

   // Advance one edge, sample 1 time unit later, and score any write or kick seen.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (writeData === 1'b1) begin
         chk("wr_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(address), 64'(e.addr));
            chk("wr_data", 64'(rom_output), 64'(e.data));
         end
      end
      if (start_network_controller === 1'b1) begin
         dones++;
         chk("kick_quiet", 64'({writeData, address, rom_output}), 64'd0);
      end
   endtask

   task automatic expect_run();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wr_strobe", 64'(writeData), 64'd1);
      end
      step();
      chk("kick_pulse", 64'(start_network_controller), 64'd1);
      chk("kick_wr_low", 64'(writeData), 64'd0);
`ifdef ROM_CTRL_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'hFFFF_FFFF);
`endif
      step();
      chk("idle_after", 64'({start_network_controller, writeData, address, rom_output}), 64'd0);
      exp_dones++;
   endtask

   initial begin
      total = 0; bad = 0; dones = 0; exp_dones = 0;
      rom_ref[0] = 32'h1111_1111;
      rom_ref[1] = 32'h2222_2222;
      rom_ref[2] = 32'h4444_4444;
      rom_ref[3] = 32'h8888_8888;
      reset = 1'b0;
      start = 1'b0;

      // reset held
      repeat (3) step();
      chk("rst_outputs", 64'({start_network_controller, writeData, address, rom_output}), 64'd0);
      reset = 1'b1;
      repeat (2) step();
      chk("rst_release", 64'({start_network_controller, writeData, address, rom_output}), 64'd0);

      // single start pulse
      start = 1'b1;
      push_run();
      step();
      chk("trig_edge_quiet", 64'(writeData), 64'd0);
      start = 1'b0;
      expect_run();
      chk("run1_queue", 64'(exp_q.size()), 64'd0);
      chk("run1_dones", 64'(dones), 64'(exp_dones));

      // held start
      start = 1'b1;
      push_run();
      step();
      expect_run();
      repeat (14) step();
      start = 1'b0;
      step();
      chk("held_queue", 64'(exp_q.size()), 64'd0);
      chk("held_dones", 64'(dones), 64'(exp_dones));

      // retrigger during word 2 is ignored
      start = 1'b1;
      push_run();
      step();
      start = 1'b0;
      step();
      step();
      start = 1'b1;
      step();
      chk("retrig_w2_addr", 64'(address), 64'd2);
      start = 1'b0;
      step();
      step();
      chk("retrig_kick", 64'(start_network_controller), 64'd1);
      exp_dones++;
      repeat (4) begin
         step();
         chk("retrig_ignored", 64'(writeData), 64'd0);
      end
      start = 1'b1;
      push_run();
      step();
      start = 1'b0;
      expect_run();
      chk("retrig_dones", 64'(dones), 64'(exp_dones));

      // abort mid-transfer
      start = 1'b1;
      push_run();
      step();
      start = 1'b0;
      step();
      step();
      chk("abort_at_addr1", 64'(address), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort_async", 64'({start_network_controller, writeData, address, rom_output}), 64'd0);
      chk("abort_consumed", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      repeat (2) step();
      reset = 1'b1;
      repeat (6) step();
      chk("abort_no_kick", 64'(dones), 64'(exp_dones));
      start = 1'b1;
      push_run();
      step();
      start = 1'b0;
      expect_run();
      chk("post_abort_queue", 64'(exp_q.size()), 64'd0);
      chk("final_dones", 64'(dones), 64'(exp_dones));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
